idct_8x8_engine: RTL and testbench

- Inverse 2D 8x8 DCT engine, the decode-side counterpart of the forward DCT datapath and its basis-cosine lookup tables.
- Accepts 64 coefficients F[k1][k2] on a valid/ready stream and buffers them. Reconstructs each pixel f[n1][n2] with a serial multiply-accumulate over all 64 basis terms. Emits the 64 pixels on a second valid/ready stream.
- Sits between the coefficient decode/dequant stage and the pixel reconstruction buffer.

---
 rtl/idct_8x8_engine.sv | 195 +++++++++++++++++++
 tb/tb_idct_8x8_engine.sv | 383 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/idct_8x8_engine.sv
// Serial-MAC inverse 8x8 DCT: buffers 64 coefficients, rebuilds each pixel over 64 cycles.
// Optional IDCT_LEVEL_SHIFT_EN: +128 level shift with [0,255] clamp on out_data.
module idct_8x8_engine #(
    parameter int unsigned COEF_W = 16,
    parameter int unsigned OUT_W  = 16,
    parameter int unsigned ACC_W  = 40
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              coef_valid,
    output logic              coef_ready,
    input  logic [COEF_W-1:0] coef_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OUT_W-1:0]  out_data,
    output logic              out_last,
    output logic              busy
);

    typedef enum logic [1:0] {StLoad, StMac, StEmit} state_e;

    localparam logic signed [ACC_W-1:0] RoundBias = ACC_W'(1) << 15;
`ifdef IDCT_LEVEL_SHIFT_EN
    localparam logic signed [ACC_W-1:0] LvlOffset = ACC_W'(128);
    localparam logic signed [ACC_W-1:0] LvlMax    = ACC_W'(255);
`else
    localparam logic signed [ACC_W-1:0] SatMax = (ACC_W'(1) << (OUT_W - 1)) - ACC_W'(1);
    localparam logic signed [ACC_W-1:0] SatMin = -SatMax - ACC_W'(1);
`endif

    state_e state_q, state_d;
    logic [5:0] cidx_q, cidx_d;
    logic [5:0] p_q, p_d;
    logic [5:0] t_q, t_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic ready_en_q;

    logic signed [COEF_W-1:0] coef_buf [64];

    // C[k][n] = round(256*a(k)*cos((2n+1)k*pi/16)) folded onto one quarter-wave table
    function automatic logic signed [8:0] basis(input logic [2:0] k, input logic [2:0] n);
        int m;
        int f;
        int mag;
        if (k == 3'd0) begin
            return 9'sd91;
        end
        m = ((2 * int'(n) + 1) * int'(k)) % 32;
        if (m > 16) m = 32 - m;
        f = (m > 8) ? 16 - m : m;
        case (f)
            0:       mag = 128;
            1:       mag = 126;
            2:       mag = 118;
            3:       mag = 106;
            4:       mag = 91;
            5:       mag = 71;
            6:       mag = 49;
            7:       mag = 25;
            default: mag = 0;
        endcase
        return (m > 8) ? 9'(-mag) : 9'(mag);
    endfunction

    logic signed [8:0]          c_row;
    logic signed [8:0]          c_col;
    logic signed [17:0]         c_prod;
    logic signed [COEF_W+17:0]  term;
    logic signed [ACC_W-1:0]    term_ext;
    logic signed [ACC_W-1:0]    acc_rnd;
    logic signed [ACC_W-1:0]    acc_shr;
    logic [OUT_W-1:0]           pix;

    // k1 pairs with n1 (row), k2 with n2 (column)
    assign c_row    = basis(t_q[5:3], p_q[5:3]);
    assign c_col    = basis(t_q[2:0], p_q[2:0]);
    assign c_prod   = c_row * c_col;
    assign term     = coef_buf[t_q] * c_prod;
    assign term_ext = {{(ACC_W - COEF_W - 18){term[COEF_W+17]}}, term};

    assign acc_rnd = acc_q + RoundBias;
    assign acc_shr = acc_rnd >>> 16;

`ifdef IDCT_LEVEL_SHIFT_EN
    logic signed [ACC_W-1:0] lvl;
    assign lvl = acc_shr + LvlOffset;

    always_comb begin
        if (lvl[ACC_W-1]) begin
            pix = '0;
        end else if (lvl > LvlMax) begin
            pix = OUT_W'(8'hff);
        end else begin
            pix = OUT_W'(lvl[7:0]);
        end
    end
`else
    always_comb begin
        if (acc_shr > SatMax) begin
            pix = SatMax[OUT_W-1:0];
        end else if (acc_shr < SatMin) begin
            pix = SatMin[OUT_W-1:0];
        end else begin
            pix = acc_shr[OUT_W-1:0];
        end
    end
`endif

    // Coefficient store has no reset; contents are don't-care until rewritten
    always_ff @(posedge clk) begin
        if (coef_valid && coef_ready) begin
            coef_buf[cidx_q] <= coef_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StLoad;
            cidx_q     <= '0;
            p_q        <= '0;
            t_q        <= '0;
            acc_q      <= '0;
            ready_en_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cidx_q     <= cidx_d;
            p_q        <= p_d;
            t_q        <= t_d;
            acc_q      <= acc_d;
            ready_en_q <= 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        cidx_d  = cidx_q;
        p_d     = p_q;
        t_d     = t_q;
        acc_d   = acc_q;
        unique case (state_q)
            StLoad: begin
                if (coef_valid && coef_ready) begin
                    cidx_d = cidx_q + 6'd1;
                    if (cidx_q == 6'd63) begin
                        state_d = StMac;
                        p_d     = '0;
                        t_d     = '0;
                        acc_d   = '0;
                    end
                end
            end
            StMac: begin
                acc_d = acc_q + term_ext;
                t_d   = t_q + 6'd1;
                if (t_q == 6'd63) begin
                    state_d = StEmit;
                end
            end
            StEmit: begin
                if (out_ready) begin
                    if (p_q == 6'd63) begin
                        state_d = StLoad;
                        cidx_d  = '0;
                    end else begin
                        state_d = StMac;
                        p_d     = p_q + 6'd1;
                        t_d     = '0;
                        acc_d   = '0;
                    end
                end
            end
            default: state_d = StLoad;
        endcase
    end

    always_comb begin
        coef_ready = 1'b0;
        out_valid  = 1'b0;
        out_data   = '0;
        out_last   = 1'b0;
        busy       = 1'b0;
        unique case (state_q)
            StLoad: coef_ready = ready_en_q;
            StMac:  busy = 1'b1;
            StEmit: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                out_data  = pix;
                out_last  = (p_q == 6'd63);
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_idct_8x8_engine.sv
// Self-checking bench for idct_8x8_engine against a real-arithmetic IDCT reference.
module tb_idct_8x8_engine;

    localparam int COEF_W = 16;
    localparam int OUT_W  = 16;
    localparam int ACC_W  = 40;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              coef_valid = 1'b0;
    logic              coef_ready;
    logic [COEF_W-1:0] coef_data = '0;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [OUT_W-1:0]  out_data;
    logic              out_last;
    logic              busy;

    idct_8x8_engine #(
        .COEF_W(COEF_W),
        .OUT_W (OUT_W),
        .ACC_W (ACC_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .coef_valid(coef_valid),
        .coef_ready(coef_ready),
        .coef_data (coef_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    int cref [8][8];
    int coefs [64];
    int exp_px [64];
    int got [64];
    bit got_last [64];
    int got_cyc [64];
    int last_acc_cyc;
    bit timeout;
    int busy_low, ready_seen, stall_changes, spurious_last;

    function automatic int model_px(input int idx);
        longint s;
        longint r;
        int n1;
        int n2;
        s  = 0;
        n1 = idx / 8;
        n2 = idx % 8;
        for (int k1 = 0; k1 < 8; k1++) begin
            for (int k2 = 0; k2 < 8; k2++) begin
                s += longint'(coefs[k1*8+k2]) * longint'(cref[k1][n1]) * longint'(cref[k2][n2]);
            end
        end
        r = (s + 64'sd32768) >>> 16;
`ifdef IDCT_LEVEL_SHIFT_EN
        r = r + 128;
        if (r < 0) r = 0;
        if (r > 255) r = 255;
`else
        if (r > 32767) r = 32767;
        if (r < -32768) r = -32768;
`endif
        return int'(r);
    endfunction

    function automatic int px_value(input logic [OUT_W-1:0] d);
`ifdef IDCT_LEVEL_SHIFT_EN
        return int'(d);
`else
        return int'($signed(d));
`endif
    endfunction

    task automatic build_expect();
        for (int i = 0; i < 64; i++) exp_px[i] = model_px(i);
    endtask

    // Drive coefs[] into the engine with random idle gaps; records the acceptance cycle of index 63.
    task automatic load_block();
        int i;
        int budget;
        i = 0;
        budget = 0;
        timeout = 0;
        while (i < 64) begin
            @(negedge clk);
            budget++;
            if (budget > 1000) begin
                timeout = 1;
                break;
            end
            if ($urandom_range(0, 3) == 0) begin
                coef_valid = 1'b0;
                coef_data  = COEF_W'($urandom);
            end else begin
                coef_valid = 1'b1;
                coef_data  = COEF_W'(coefs[i]);
                if (coef_ready === 1'b1) begin
                    if (i == 63) last_acc_cyc = cyc;
                    i++;
                end
            end
        end
    endtask

    // Gather 64 output pixels; stall_pix is held off for stall_len cycles.
    task automatic collect(input int stall_pix, input int stall_len, input bit pulse);
        int n;
        int stall_cnt;
        int budget;
        logic [OUT_W-1:0] hold_d;
        logic hold_l;
        n = 0;
        stall_cnt = 0;
        budget = 0;
        hold_d = '0;
        hold_l = 1'b0;
        busy_low = 0;
        ready_seen = 0;
        stall_changes = 0;
        spurious_last = 0;
        while (n < 64) begin
            @(negedge clk);
            budget++;
            if (budget > 6000) begin
                timeout = 1;
                break;
            end
            coef_valid = pulse ? 1'($urandom_range(0, 1)) : 1'b0;
            coef_data  = COEF_W'($urandom);
            if (busy !== 1'b1) busy_low++;
            if (coef_ready !== 1'b0) ready_seen++;
            if (out_valid !== 1'b1 && out_last === 1'b1) spurious_last++;
            if (out_valid === 1'b1) begin
                if (n == stall_pix && stall_cnt < stall_len) begin
                    if (stall_cnt == 0) begin
                        hold_d = out_data;
                        hold_l = out_last;
                    end else if (out_data !== hold_d || out_last !== hold_l) begin
                        stall_changes++;
                    end
                    stall_cnt++;
                    out_ready = 1'b0;
                end else begin
                    if (n == stall_pix && stall_cnt > 0 && (out_data !== hold_d || out_last !== hold_l))
                        stall_changes++;
                    got[n]      = px_value(out_data);
                    got_last[n] = out_last;
                    got_cyc[n]  = cyc;
                    n++;
                    out_ready = 1'b1;
                end
            end else begin
                out_ready = 1'($urandom_range(0, 1));
            end
        end
        coef_valid = 1'b0;
        out_ready  = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || out_last !== 1'b0 || busy !== 1'b0 || out_data !== '0) begin
            errors++;
            $display("FAIL reset_outputs: valid=%b last=%b busy=%b data=%0h, required 0/0/0/0",
                     out_valid, out_last, busy, out_data);
        end
        checks++;
        if (coef_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_coef_ready: got %b, required 0", coef_ready);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (coef_ready !== 1'b1) begin
            errors++;
            $display("FAIL load_coef_ready: got %b, required 1", coef_ready);
        end
    endtask

    // Full-rate block: pixel values, out_last placement and exact per-pixel timing.
    task automatic test_block(input string name);
        int bad_px;
        int bad_last;
        int bad_cyc;
        build_expect();
        load_block();
        collect(-1, 0, 1'b0);
        checks++;
        if (timeout) begin
            errors++;
            $display("FAIL %s_timeout: block did not complete", name);
        end
        bad_px = 0;
        bad_last = 0;
        bad_cyc = 0;
        for (int i = 0; i < 64; i++) begin
            checks++;
            if (got[i] !== exp_px[i]) begin
                errors++;
                bad_px++;
                if (bad_px < 4) $display("FAIL %s_pixel[%0d]: got %0d, required %0d", name, i, got[i], exp_px[i]);
            end
            if (got_last[i] !== (i == 63)) bad_last++;
            if (got_cyc[i] != last_acc_cyc + 65 + 65 * i) bad_cyc++;
        end
        checks++;
        if (bad_last != 0) begin
            errors++;
            $display("FAIL %s_out_last: %0d misplaced, required 0", name, bad_last);
        end
        checks++;
        if (got_cyc[0] != last_acc_cyc + 65) begin
            errors++;
            $display("FAIL %s_latency: first pixel at +%0d, required +65", name, got_cyc[0] - last_acc_cyc);
        end
        checks++;
        if (bad_cyc != 0) begin
            errors++;
            $display("FAIL %s_pixel_timing: %0d off-schedule pixels, required 0", name, bad_cyc);
        end
        checks++;
        if (busy_low != 0 || spurious_last != 0) begin
            errors++;
            $display("FAIL %s_busy: busy low %0d cycles, stray last %0d, required 0/0", name, busy_low, spurious_last);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || coef_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s_return_load: busy=%b ready=%b valid=%b, required 0/1/0", name, busy, coef_ready, out_valid);
        end
    endtask

    task automatic test_dc();
        foreach (coefs[i]) coefs[i] = 0;
        coefs[0] = 512;
        test_block("dc");
    endtask

    task automatic test_zero();
        foreach (coefs[i]) coefs[i] = 0;
        test_block("zero");
    endtask

    task automatic test_neg_dc();
        foreach (coefs[i]) coefs[i] = 0;
        coefs[0] = -1024;
        test_block("neg_dc");
    endtask

    task automatic test_ac();
        foreach (coefs[i]) coefs[i] = 0;
        coefs[1] = 1024;
        test_block("ac01");
    endtask

    task automatic test_saturate();
        foreach (coefs[i]) coefs[i] = 32767;
        test_block("saturate");
    endtask

    task automatic test_random();
        for (int b = 0; b < 2; b++) begin
            foreach (coefs[i]) coefs[i] = int'($urandom_range(0, 4000)) - 2000;
            test_block("random");
        end
    endtask

    task automatic test_back_to_back();
        foreach (coefs[i]) coefs[i] = int'($urandom_range(0, 600)) - 300;
        build_expect();
        load_block();
        collect(5, 10, 1'b1);
        checks++;
        if (timeout) begin
            errors++;
            $display("FAIL stall_timeout: block did not complete");
        end
        for (int i = 0; i < 64; i++) begin
            checks++;
            if (got[i] !== exp_px[i]) begin
                errors++;
                $display("FAIL stall_pixel[%0d]: got %0d, required %0d", i, got[i], exp_px[i]);
            end
        end
        checks++;
        if (stall_changes != 0) begin
            errors++;
            $display("FAIL stall_hold: output changed %0d times, required 0", stall_changes);
        end
        checks++;
        if (got_cyc[5] != last_acc_cyc + 65 + 325 + 10 || got_cyc[6] != last_acc_cyc + 65 + 390 + 10) begin
            errors++;
            $display("FAIL stall_timing: p5 +%0d p6 +%0d, required +400 +465",
                     got_cyc[5] - last_acc_cyc, got_cyc[6] - last_acc_cyc);
        end
        checks++;
        if (ready_seen != 0) begin
            errors++;
            $display("FAIL stall_coef_ready: high %0d cycles while busy, required 0", ready_seen);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int target;
        int budget;
        foreach (coefs[i]) coefs[i] = int'($urandom_range(0, 2000)) - 1000;
        load_block();
        coef_valid = 1'b0;
        out_ready = 1'b1;
        target = last_acc_cyc + 1 + 65 * 12 + 30;
        budget = 0;
        while (cyc < target && budget < 2000) begin
            @(negedge clk);
            budget++;
        end
        checks++;
        if (cyc != target) begin
            errors++;
            $display("FAIL midreset_reach: at cycle %0d, required %0d", cyc, target);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || coef_ready !== 1'b0) begin
            errors++;
            $display("FAIL midreset_outputs: valid=%b busy=%b ready=%b, required 0/0/0", out_valid, busy, coef_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (coef_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL midreset_load: ready=%b valid=%b, required 1/0", coef_ready, out_valid);
        end
        foreach (coefs[i]) coefs[i] = 0;
        coefs[0] = 512;
        test_block("after_reset");
    endtask

    initial begin
        for (int k = 0; k < 8; k++) begin
            for (int n = 0; n < 8; n++) begin
                real a;
                real v;
                a = (k == 0) ? $sqrt(1.0 / 8.0) : 0.5;
                v = 256.0 * a * $cos(real'((2 * n + 1) * k) * 3.14159265358979 / 16.0);
                cref[k][n] = (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(-v + 0.5);
            end
        end
        test_reset();
        test_dc();
        test_zero();
        test_neg_dc();
        test_ac();
        test_saturate();
        test_random();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
